// File: rtl/arf070b144e1r1w0cbbeheaa4acw_bcam_mbist_seq.sv
// rtl/arf070b144e1r1w0cbbeheaa4acw_bcam_mbist_seq.sv - BCAM MBIST sequencer (write / hit-compare / walking-mask miss-compare)
//
// Purpose: runs a two-background march over the BCAM. For each background
// (true, then inverted) every entry is written with the 0x55..5 pattern,
// one hit compare expects all entries to match, then one miss compare per
// walking-mask position expects no entry to match. pass reports the result.
//
// Ports:
//   bist_clk, bist_rst      clock, synchronous active-high reset
//   start                   one-cycle test request (ignored while busy)
//   busy, done, pass        status: in progress, end pulse, sticky result
//   bist_wr_en/addr/data    CAM write port (data is the true background)
//   bist_cm_mode            handler-generated compare data select
//   bist_cd_mask_enable     apply walking-mask flip to compare data
//   bist_rotate_mask        one-cycle walking-mask rotate
//   bist_data_inv           background select (0 = true, 1 = inverted)
//   bist_cm_en              issue one compare
//   cm_hit_vec              per-entry match result, valid CM_LAT cycles after bist_cm_en
//
// Optional feature macro: BCAM_SEQ_FAIL_LOG_EN adds fail_valid, fail_bg,
// fail_bit (RF_DWIDTH means the hit compare) and fail_vec, which capture
// the first failing compare of a test.

module arf070b144e1r1w0cbbeheaa4acw_bcam_mbist_seq #(
  parameter int RF_DWIDTH = 72,
  parameter int RF_DEPTH  = 64,
  parameter int AWIDTH    = 6,
  parameter int CM_LAT    = 2
) (
  input  logic                            bist_clk,
  input  logic                            bist_rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic                            bist_wr_en,
  output logic [AWIDTH-1:0]               bist_wr_addr,
  output logic [RF_DWIDTH-1:0]            bist_wr_data,
  output logic                            bist_cm_mode,
  output logic                            bist_cd_mask_enable,
  output logic                            bist_rotate_mask,
  output logic                            bist_data_inv,
  output logic                            bist_cm_en,
`ifdef BCAM_SEQ_FAIL_LOG_EN
  output logic                            fail_valid,
  output logic                            fail_bg,
  output logic [$clog2(RF_DWIDTH+1)-1:0]  fail_bit,
  output logic [RF_DEPTH-1:0]             fail_vec,
`endif
  input  logic [RF_DEPTH-1:0]             cm_hit_vec
);

  localparam int BW = $clog2(RF_DWIDTH + 1);

  function automatic logic [RF_DWIDTH-1:0] bg_pattern();
    logic [RF_DWIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < RF_DWIDTH; i++) p[i] = (i % 2 == 0);
    return p;
  endfunction

  localparam logic [RF_DWIDTH-1:0] BG_PAT = bg_pattern();

  typedef enum logic [3:0] {
    S_IDLE, S_WRITE, S_CMP_HIT, S_WAIT_HIT, S_CMP_MISS,
    S_WAIT_MISS, S_ROTATE, S_NEXT_BG, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [AWIDTH-1:0] entry_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [2:0]        wait_cnt;

  logic entry_last, wait_last, bit_last, start_acc;
  logic cmp_sample, cmp_bad;

  assign entry_last = (entry_cnt == AWIDTH'(RF_DEPTH - 1));
  assign wait_last  = (wait_cnt == 3'(CM_LAT - 1));
  assign bit_last   = (bit_cnt == BW'(RF_DWIDTH - 1));
  assign start_acc  = (state == S_IDLE) && start;

  // The match vector is only meaningful in the final wait cycle.
  assign cmp_sample = ((state == S_WAIT_HIT) || (state == S_WAIT_MISS)) && wait_last;
  assign cmp_bad    = (state == S_WAIT_HIT) ? (cm_hit_vec != '1) : (cm_hit_vec != '0);

  // State register
  always_ff @(posedge bist_clk) begin
    if (bist_rst) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_WRITE;
      S_WRITE:     if (entry_last) state_nxt = S_CMP_HIT;
      S_CMP_HIT:   state_nxt = S_WAIT_HIT;
      S_WAIT_HIT:  if (wait_last) state_nxt = S_CMP_MISS;
      S_CMP_MISS:  state_nxt = S_WAIT_MISS;
      S_WAIT_MISS: if (wait_last) state_nxt = S_ROTATE;
      // After the last rotate the mask is back at bit 0 for the next background.
      S_ROTATE:    state_nxt = bit_last ? S_NEXT_BG : S_CMP_MISS;
      S_NEXT_BG:   state_nxt = bist_data_inv ? S_DONE : S_WRITE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy                = (state != S_IDLE) && (state != S_DONE);
    done                = (state == S_DONE);
    bist_wr_en          = (state == S_WRITE);
    bist_wr_addr        = bist_wr_en ? entry_cnt : '0;
    bist_wr_data        = bist_wr_en ? BG_PAT : '0;
    bist_cm_mode        = (state == S_CMP_HIT) || (state == S_WAIT_HIT) ||
                          (state == S_CMP_MISS) || (state == S_WAIT_MISS) ||
                          (state == S_ROTATE);
    bist_cd_mask_enable = (state == S_CMP_MISS);
    bist_rotate_mask    = (state == S_ROTATE);
    bist_cm_en          = (state == S_CMP_HIT) || (state == S_CMP_MISS);
  end

  // Counters, background select and result
  always_ff @(posedge bist_clk) begin
    if (bist_rst) begin
      entry_cnt     <= '0;
      bit_cnt       <= '0;
      wait_cnt      <= '0;
      pass          <= 1'b1;
      bist_data_inv <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pass          <= 1'b1;
            bist_data_inv <= 1'b0;
            entry_cnt     <= '0;
            bit_cnt       <= '0;
          end
        end
        // Hold at the last entry rather than wrapping the address.
        S_WRITE: if (!entry_last) entry_cnt <= entry_cnt + 1'b1;
        S_CMP_HIT, S_CMP_MISS: wait_cnt <= '0;
        S_WAIT_HIT, S_WAIT_MISS: begin
          if (!wait_last)   wait_cnt <= wait_cnt + 1'b1;
          else if (cmp_bad) pass     <= 1'b0;
        end
        S_ROTATE: bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
        S_NEXT_BG: begin
          if (!bist_data_inv) begin
            bist_data_inv <= 1'b1;
            entry_cnt     <= '0;
          end
        end
        S_DONE: bist_data_inv <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef BCAM_SEQ_FAIL_LOG_EN
  // First-failure capture; later failures only clear pass.
  always_ff @(posedge bist_clk) begin
    if (bist_rst || start_acc) begin
      fail_valid <= 1'b0;
      fail_bg    <= 1'b0;
      fail_bit   <= '0;
      fail_vec   <= '0;
    end else if (cmp_sample && cmp_bad && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_bg    <= bist_data_inv;
      fail_bit   <= (state == S_WAIT_HIT) ? BW'(RF_DWIDTH) : bit_cnt;
      fail_vec   <= cm_hit_vec;
    end
  end
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc | cmp_sample;
`endif

endmodule

// File: tb/tb_arf070b144e1r1w0cbbeheaa4acw_bcam_mbist_seq.sv
// tb/tb_arf070b144e1r1w0cbbeheaa4acw_bcam_mbist_seq.sv - directed bench for the BCAM MBIST sequencer

module tb_arf070b144e1r1w0cbbeheaa4acw_bcam_mbist_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  // default-parameter instance
  logic        busy, done, pass, wr_en, cm_mode, mask_en, rot, inv, cm_en;
  logic [5:0]  wr_addr;
  logic [71:0] wr_data;
  logic [63:0] hit_vec;
`ifdef BCAM_SEQ_FAIL_LOG_EN
  logic        fail_valid, fail_bg;
  logic [6:0]  fail_bit;
  logic [63:0] fail_vec;
  logic        fail_valid2, fail_bg2;
  logic [3:0]  fail_bit2;
  logic [3:0]  fail_vec2;
`endif

  // small instance: RF_DEPTH=4, RF_DWIDTH=8, CM_LAT=1
  logic        busy2, done2, pass2, wr_en2, cm_mode2, mask_en2, rot2, inv2, cm_en2;
  logic [1:0]  wr_addr2;
  logic [7:0]  wr_data2;
  logic [3:0]  hit_vec2;

  arf070b144e1r1w0cbbeheaa4acw_bcam_mbist_seq dut (
    .bist_clk(clk), .bist_rst(rst), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .bist_wr_en(wr_en), .bist_wr_addr(wr_addr), .bist_wr_data(wr_data),
    .bist_cm_mode(cm_mode), .bist_cd_mask_enable(mask_en),
    .bist_rotate_mask(rot), .bist_data_inv(inv), .bist_cm_en(cm_en),
`ifdef BCAM_SEQ_FAIL_LOG_EN
    .fail_valid(fail_valid), .fail_bg(fail_bg), .fail_bit(fail_bit), .fail_vec(fail_vec),
`endif
    .cm_hit_vec(hit_vec)
  );

  arf070b144e1r1w0cbbeheaa4acw_bcam_mbist_seq #(
    .RF_DWIDTH(8), .RF_DEPTH(4), .AWIDTH(2), .CM_LAT(1)
  ) dut2 (
    .bist_clk(clk), .bist_rst(rst), .start(start2),
    .busy(busy2), .done(done2), .pass(pass2),
    .bist_wr_en(wr_en2), .bist_wr_addr(wr_addr2), .bist_wr_data(wr_data2),
    .bist_cm_mode(cm_mode2), .bist_cd_mask_enable(mask_en2),
    .bist_rotate_mask(rot2), .bist_data_inv(inv2), .bist_cm_en(cm_en2),
`ifdef BCAM_SEQ_FAIL_LOG_EN
    .fail_valid(fail_valid2), .fail_bg(fail_bg2), .fail_bit(fail_bit2), .fail_vec(fail_vec2),
`endif
    .cm_hit_vec(hit_vec2)
  );

  // CAM + input-handler model for the default instance.
  // fault: 0 ideal, 1 entry 5 stuck-miss on inverted bg, 2 mask bit 17 ignored on true bg
  localparam logic [71:0] BG  = 72'h555555555555555555;
  localparam logic [7:0]  BG2 = 8'h55;
  int          fault = 0;
  logic [71:0] mem [64];
  int          pos;
  logic [63:0] pipe0, pipe1;

  function automatic logic [63:0] lookup(input logic [71:0] key, input logic bg);
    logic [63:0] r;
    logic [71:0] care;
    care = '1;
    if (fault == 2 && !bg) care[17] = 1'b0;
    for (int e = 0; e < 64; e++)
      r[e] = (((mem[e] ^ key) & care) == '0) && !(fault == 1 && bg && e == 5);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) pos <= 0;
    else if (rot) pos <= (pos == 71) ? 0 : pos + 1;
    if (wr_en) mem[wr_addr] <= wr_data ^ {72{inv}};
    pipe0 <= cm_en ? lookup(BG ^ {72{inv}} ^ (mask_en ? (72'd1 << pos) : 72'd0), inv)
                   : {$urandom, $urandom};
    pipe1 <= pipe0;
  end
  assign hit_vec = pipe1;

  // Ideal model for the small instance (one-cycle compare latency).
  logic [7:0] mem2 [4];
  int         pos2;
  logic [3:0] pipe2;

  function automatic logic [3:0] lookup2(input logic [7:0] key);
    logic [3:0] r;
    for (int e = 0; e < 4; e++) r[e] = (mem2[e] == key);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) pos2 <= 0;
    else if (rot2) pos2 <= (pos2 == 7) ? 0 : pos2 + 1;
    if (wr_en2) mem2[wr_addr2] <= wr_data2 ^ {8{inv2}};
    pipe2 <= cm_en2 ? lookup2(BG2 ^ {8{inv2}} ^ (mask_en2 ? (8'd1 << pos2) : 8'd0))
                    : 4'($urandom);
  end
  assign hit_vec2 = pipe2;

  // Activity counters, sampled on the falling edge.
  int busy_c, done_c, wr_c, cm_c, miss_c, rot_c, overlap_c, badmode_c;
  int busy2_c, done2_c, wr2_c, cm2_c, rot2_c;

  always @(negedge clk) begin
    if (clr) begin
      busy_c = 0; done_c = 0; wr_c = 0; cm_c = 0; miss_c = 0; rot_c = 0;
      overlap_c = 0; badmode_c = 0;
      busy2_c = 0; done2_c = 0; wr2_c = 0; cm2_c = 0; rot2_c = 0;
    end
    if (busy) busy_c++;
    if (done) done_c++;
    if (wr_en) wr_c++;
    if (cm_en) cm_c++;
    if (cm_en && mask_en) miss_c++;
    if (rot) rot_c++;
    if (wr_en && cm_en) overlap_c++;
    if (cm_en && !cm_mode) badmode_c++;
    if (busy2) busy2_c++;
    if (done2) done2_c++;
    if (wr_en2) wr2_c++;
    if (cm_en2) cm2_c++;
    if (rot2) rot2_c++;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1; clr = 1'b1; start = 1'b1;
    @(posedge clk); #1; clr = 1'b0; start = 1'b0;
    check("start_busy", busy, 1);
    check("start_wr_en", wr_en, 1);
    check("start_wr_addr", wr_addr, 0);
    check("start_pass", pass, 1);
  endtask

  task automatic wait_done(input int restart_at);
    bit seen;
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(posedge clk); #1;
      start = (i == restart_at);
      if (done) seen = 1;
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 1);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_cm_mode"}, cm_mode, 0);
    check({tag, "_mask_en"}, mask_en, 0);
    check({tag, "_rotate"}, rot, 0);
    check({tag, "_data_inv"}, inv, 0);
    check({tag, "_cm_en"}, cm_en, 0);
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check("rst_busy2", busy2, 0);
    check("rst_pass2", pass2, 1);
    rst = 1'b0;
    @(posedge clk); #1;
`ifdef BCAM_SEQ_FAIL_LOG_EN
    check("rst_fail_valid", fail_valid, 0);
`endif

    // ideal CAM: full passing test
    fault = 0;
    do_start();
    @(negedge clk);
    check("first_wr_data", wr_data, BG);
    wait_done(-1);
    check("ideal_busy_len", busy_c, 712);
    check("ideal_done_cnt", done_c, 1);
    check("ideal_pass", pass, 1);
    check("ideal_writes", wr_c, 128);
    check("ideal_compares", cm_c, 146);
    check("ideal_miss_compares", miss_c, 144);
    check("ideal_rotates", rot_c, 144);
    check("ideal_wr_cm_overlap", overlap_c, 0);
    check("ideal_cm_mode_low", badmode_c, 0);
    check("ideal_idle_inv", inv, 0);
    check("ideal_idle_cm_mode", cm_mode, 0);
`ifdef BCAM_SEQ_FAIL_LOG_EN
    check("ideal_fail_valid", fail_valid, 0);
`endif

    // entry 5 stuck-miss on inverted background
    fault = 1;
    do_start();
    wait_done(-1);
    check("stuck_pass", pass, 0);
    check("stuck_busy_len", busy_c, 712);
    check("stuck_compares", cm_c, 146);
`ifdef BCAM_SEQ_FAIL_LOG_EN
    check("stuck_fail_valid", fail_valid, 1);
    check("stuck_fail_bg", fail_bg, 1);
    check("stuck_fail_bit", fail_bit, 72);
    check("stuck_fail_vec", fail_vec, 64'hFFFF_FFFF_FFFF_FFDF);
`endif

    // mask bit 17 ignored on true background; start restores pass
    fault = 2;
    do_start();
`ifdef BCAM_SEQ_FAIL_LOG_EN
    check("ign_fail_cleared", fail_valid, 0);
`endif
    wait_done(-1);
    check("ign_pass", pass, 0);
    check("ign_done_cnt", done_c, 1);
`ifdef BCAM_SEQ_FAIL_LOG_EN
    check("ign_fail_valid", fail_valid, 1);
    check("ign_fail_bg", fail_bg, 0);
    check("ign_fail_bit", fail_bit, 17);
    check("ign_fail_vec", fail_vec, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

    // start pulsed mid-test is ignored
    fault = 0;
    do_start();
    wait_done(300);
    check("restart_busy_len", busy_c, 712);
    check("restart_done_cnt", done_c, 1);
    check("restart_pass", pass, 1);

    // reset mid-test abandons without done, then a full test runs
    fault = 1;
    do_start();
    repeat (399) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_done", done_c, 0);
    check("midrst_idle", busy, 0);
    fault = 0;
    do_start();
    wait_done(-1);
    check("postrst_busy_len", busy_c, 712);
    check("postrst_pass", pass, 1);
    check("postrst_done_cnt", done_c, 1);

    // small configuration, CM_LAT = 1
    @(posedge clk); #1; clr = 1'b1; start2 = 1'b1;
    @(posedge clk); #1; clr = 1'b0; start2 = 1'b0;
    check("small_start_busy", busy2, 1);
    begin
      bit seen2;
      seen2 = 0;
      for (int i = 0; i < 500 && !seen2; i++) begin
        @(posedge clk); #1;
        if (done2) seen2 = 1;
      end
      check("small_done_seen", seen2, 1);
    end
    @(posedge clk); #1;
    check("small_busy_len", busy2_c, 62);
    check("small_done_cnt", done2_c, 1);
    check("small_pass", pass2, 1);
    check("small_writes", wr2_c, 8);
    check("small_compares", cm2_c, 18);
    check("small_rotates", rot2_c, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
